// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg: beat-type codes shared by initiator and responder, plus the responder state encoding
package bus_responder_pkg;
  localparam logic [1:0] CTRL_ADDR0 = 2'd0;
  localparam logic [1:0] CTRL_ADDR1 = 2'd1;
  localparam logic [1:0] CTRL_ADDR2 = 2'd2;
  localparam logic [1:0] CTRL_DATA  = 2'd3;
  typedef enum logic [1:0] {IDLE, MEM_WAIT, ACK_HOLD} state_t;
endpackage

// File: rtl/bus_responder_sync_edge.sv
// sync_edge: two-flop synchronizer with rise/fall detect (clk, reset, d in; rise, fall out)
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic s1, s2;
  always_ff @(posedge clk)
    if (reset) {s1, s2} <= 2'b00;
    else {s1, s2} <= {d, s1};
  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;
endmodule

// File: rtl/bus_responder.sv
// bus_responder: rdy/ack beat responder assembling a 16-bit address and bridging DATA beats to a backing store (clk, reset, rdy, bus_ctrl, bus_wr, bus_data_in -> bus_data_out, ack; mem_addr, mem_wdata, mem_we, mem_re <-> mem_rdata, mem_valid); BUS_RESP_AUTOINC_EN adds post-DATA address increment
module bus_responder
  import bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic [1:0]  bus_ctrl,
  input  logic        bus_wr,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid
);
  state_t state;
  logic rdy_rise, rdy_fall;
  sync_edge u_rdy (.clk(clk), .reset(reset), .d(rdy), .rise(rdy_rise), .fall(rdy_fall));
  always_ff @(posedge clk)
    if (reset) begin
      state        <= IDLE;
      ack          <= 1'b0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      mem_addr     <= 16'h0000;
      mem_wdata    <= 8'h00;
      bus_data_out <= 8'h00;
    end else
      case (state)
        IDLE:
          if (rdy_rise) begin
            ack   <= bus_ctrl != CTRL_DATA;
            state <= bus_ctrl == CTRL_DATA ? MEM_WAIT : ACK_HOLD;
            if (bus_ctrl == CTRL_ADDR0) mem_addr[7:0] <= bus_data_in;
            if (bus_ctrl == CTRL_ADDR1) mem_addr[15:8] <= bus_data_in;
            if (bus_ctrl == CTRL_DATA) begin
              mem_we <= bus_wr;
              mem_re <= ~bus_wr;
              if (bus_wr) mem_wdata <= bus_data_in;
            end
          end
        MEM_WAIT:
          if (mem_valid) begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (mem_re) bus_data_out <= mem_rdata;
            ack   <= 1'b1;
            state <= ACK_HOLD;
`ifdef BUS_RESP_AUTOINC_EN
            mem_addr <= mem_addr + 16'd1;
`endif
          end
        ACK_HOLD:
          if (rdy_fall) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: scoreboard bench for bus_responder; expected ack responses queued by stimulus, checked by a negedge monitor
module tb_bus_responder;
  import bus_responder_pkg::*;
  logic clk = 1'b0;
  logic reset, rdy, bus_wr, mem_valid, ack, mem_we, mem_re;
  logic [1:0] bus_ctrl;
  logic [7:0] bus_data_in, bus_data_out, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  bus_responder dut (
    .clk(clk), .reset(reset), .rdy(rdy), .bus_ctrl(bus_ctrl), .bus_wr(bus_wr),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .ack(ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] dout; logic [15:0] addr;} exp_t;
  exp_t q[$];
  exp_t e;
  int passed = 0, total = 0, acks = 0, exp_acks = 0;
  logic [15:0] ea = 16'h0000;
  logic [7:0] ed = 8'h00;
  bit both_seen = 0;
  logic ack_q = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (mem_we && mem_re) both_seen = 1;
    if (ack && !ack_q) begin
      acks++;
      if (q.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        e = q.pop_front();
        chk("ack_dout", bus_data_out, e.dout);
        chk("ack_addr", mem_addr, e.addr);
      end
    end
    ack_q = ack;
  end
  task automatic push_exp();
    exp_t x;
    x.dout = ed;
    x.addr = ea;
    q.push_back(x);
    exp_acks++;
  endtask
  task automatic wait_lvl(input string name, input logic lvl, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== lvl && n < 20);
    chk(name, n, exp_n);
  endtask
  task automatic beat_start(input logic [1:0] ctrl, input logic wr, input logic [7:0] din);
    @(posedge clk); #1;
    bus_ctrl = ctrl;
    bus_wr = wr;
    bus_data_in = din;
    rdy = 1'b1;
  endtask
  task automatic beat_end();
    @(posedge clk); #1;
    rdy = 1'b0;
    wait_lvl("ack_fall", 1'b0, 3);
  endtask
  task automatic addr_beat(input logic [1:0] ctrl, input logic [7:0] din);
    if (ctrl == CTRL_ADDR0) ea[7:0] = din;
    if (ctrl == CTRL_ADDR1) ea[15:8] = din;
    push_exp();
    beat_start(ctrl, 1'b0, din);
    wait_lvl("ack_rise", 1'b1, 3);
    beat_end();
  endtask
  task automatic data_beat(input logic wr, input logic [7:0] din, input logic [7:0] rdata, input int delay);
    int n = 0;
    bit ok = 1;
    logic [15:0] a = ea;
    if (!wr) ed = rdata;
`ifdef BUS_RESP_AUTOINC_EN
    ea = ea + 16'd1;
`endif
    push_exp();
    beat_start(CTRL_DATA, wr, din);
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_we || mem_re) && n < 20);
    chk("strobe_latency", n, 3);
    chk("strobe_kind", {mem_we, mem_re}, wr ? 2'b10 : 2'b01);
    chk("strobe_addr", mem_addr, a);
    if (wr) chk("wdata", mem_wdata, din);
    repeat (delay) begin
      @(negedge clk);
      if ({mem_we, mem_re} != (wr ? 2'b10 : 2'b01) || ack) ok = 0;
    end
    chk("strobe_held", ok, 1);
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("strobe_drop", {mem_we, mem_re}, 2'b00);
    chk("ack_after_valid", ack, 1);
    beat_end();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; rdy = 1'b0; bus_ctrl = 2'd0; bus_wr = 1'b0; bus_data_in = 8'h00;
    mem_rdata = 8'h00; mem_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_dout", bus_data_out, 8'h00);
    addr_beat(CTRL_ADDR0, 8'h34);
    addr_beat(CTRL_ADDR1, 8'h12);
    chk("addr_1234", mem_addr, 16'h1234);
    data_beat(1'b1, 8'hA5, 8'h00, 3);
    data_beat(1'b0, 8'h00, 8'h5A, 2);
    addr_beat(CTRL_ADDR2, 8'h99);
    addr_beat(CTRL_ADDR0, 8'h56);
    chk("dout_hold", bus_data_out, 8'h5A);
    ea[7:0] = 8'h11;
    push_exp();
    ea[15:8] = 8'h22;
    push_exp();
    beat_start(CTRL_ADDR0, 1'b0, 8'h11);
    wait_lvl("b2b_rise0", 1'b1, 3);
    @(posedge clk); #1;
    rdy = 1'b0;
    bus_ctrl = CTRL_ADDR1;
    bus_data_in = 8'h22;
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_lvl("b2b_fall", 1'b0, 2);
    wait_lvl("b2b_rise1", 1'b1, 1);
    beat_end();
    chk("b2b_addr", mem_addr, 16'h2211);
    beat_start(CTRL_DATA, 1'b0, 8'h00);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!mem_re && n < 20);
      chk("abort_strobe", mem_re, 1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    rdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ack", ack, 0);
    chk("abort_re", mem_re, 0);
    chk("abort_addr", mem_addr, 16'h0000);
    ea = 16'h0000;
    ed = 8'h00;
    addr_beat(CTRL_ADDR0, 8'h77);
    addr_beat(CTRL_ADDR0, 8'hFF);
    addr_beat(CTRL_ADDR1, 8'hFF);
    data_beat(1'b0, 8'h00, 8'h11, 1);
    data_beat(1'b0, 8'h00, 8'h22, 1);
    chk("no_dual_strobe", both_seen, 0);
    chk("ack_count", acks, exp_acks);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, exactly as listed here:
  clk  in  1  system clock, all logic on rising edge
  reset  in  1  synchronous active-high reset
REQ-002 SHALL provide the remaining ports, one per line (name, direction, width, meaning):
  rdy  in  1  initiator request level; rising edge starts a beat
  bus_ctrl  in  2  beat type: 0=ADDR0, 1=ADDR1, 2=reserved, 3=DATA
  bus_wr  in  1  1 = DATA beat is a write; ignored for ADDR beats
  bus_data_in  in  8  byte driven by initiator
  bus_data_out  out  8  read byte returned to initiator
  ack  out  1  beat complete, held until rdy falls
  mem_addr  out  16  assembled backing-store address
  mem_wdata  out  8  write byte to backing store
  mem_we  out  1  write request level, held until mem_valid
  mem_re  out  1  read request level, held until mem_valid
  mem_rdata  in  8  backing-store read byte, valid with mem_valid
  mem_valid  in  1  backing-store completion, sampled only in MEM_WAIT

Function
REQ-003 SHALL pass rdy through a two-flop chain (rdy_s1, rdy_s2); rdy_rise = rdy_s1 & ~rdy_s2; rdy_fall = ~rdy_s1 & rdy_s2.
REQ-004 SHALL implement states IDLE, MEM_WAIT and ACK_HOLD.
REQ-005 IDLE, on rdy_rise: sample bus_ctrl, bus_wr and bus_data_in in that cycle; otherwise stay in IDLE.
REQ-006 ADDR0 beat: mem_addr[7:0] <= bus_data_in, ack <= 1, go to ACK_HOLD; ack is high one cycle after rdy_rise.
REQ-007 ADDR1 beat: mem_addr[15:8] <= bus_data_in, ack <= 1, go to ACK_HOLD.
REQ-008 Reserved code 2: ack <= 1, go to ACK_HOLD, with no change to mem_addr, mem_* or bus_data_out.
REQ-009 DATA beat with bus_wr=1: mem_wdata <= bus_data_in, mem_we <= 1, go to MEM_WAIT.
REQ-010 DATA beat with bus_wr=0: mem_re <= 1, go to MEM_WAIT.
REQ-011 MEM_WAIT, on mem_valid: mem_we <= 0 and mem_re <= 0; for a read, bus_data_out <= mem_rdata; ack <= 1; go to ACK_HOLD. Otherwise wait indefinitely.
REQ-012 ACK_HOLD, on rdy_fall: ack <= 0, go to IDLE.
REQ-013 ACK_HOLD SHALL catch a one-cycle rdy low pulse, which is visible in the sync chain. Any rdy_rise seen in ACK_HOLD SHALL be ignored; the following beat is detected from IDLE.
REQ-014 ack SHALL be low for at least one cycle between consecutive beats, so the initiator's ack edge detect re-arms.
REQ-015 mem_we and mem_re SHALL never be high together.
REQ-016 bus_data_out SHALL hold its value except when REQ-011 loads it on a read.

Reset
REQ-017 On reset the block SHALL set: state IDLE; ack=0; mem_we=0; mem_re=0; mem_addr=0x0000; mem_wdata=0x00; bus_data_out=0x00; rdy_s1=rdy_s2=0.
REQ-018 Reset in any state, including MEM_WAIT or ACK_HOLD, SHALL drop ack and the strobes on the next clock edge and abandon the beat.

Configuration
REQ-019 Macro BUS_RESP_AUTOINC_EN:
  - Defined: each completed DATA beat (read or write) increments mem_addr by 1 on the cycle ack rises; wraps 0xFFFF to 0x0000.
  - Undefined: mem_addr changes only on ADDR0/ADDR1 beats.

Structure
REQ-020 The bus_ctrl codes (ADDR0=0, ADDR1=1, ADDR2=2 reserved, DATA=3) SHALL live in the shared params include, used by both the initiator and this block.
REQ-021 Sub-module sync_edge SHALL provide the two-flop synchronizer plus rise/fall detect; it is instantiated once, for rdy.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - ADDR0 0x34 then ADDR1 0x12 -> mem_addr=0x1234; each ack rises 1 cycle after rdy_rise and falls 1 cycle after rdy_fall.
  - DATA write 0xA5 to 0x1234, mem_valid 3 cycles later -> mem_we high exactly until mem_valid, mem_wdata=0xA5, ack high the cycle after mem_valid.
  - DATA read with mem_rdata=0x5A -> mem_re pulse, bus_data_out=0x5A when ack rises; bus_data_out holds 0x5A through a following ADDR beat.
  - Back-to-back beats with a 1-cycle rdy low -> ack falls, then rises again for the next beat; no beat lost or duplicated.
  - Reset asserted in MEM_WAIT -> ack=0, mem_re=0, mem_addr=0x0000 on the next cycle; a new beat then completes normally.
  - With BUS_RESP_AUTOINC_EN: address 0xFFFF, two DATA reads -> reads at 0xFFFF then 0x0000. Without the macro: both reads at 0xFFFF.
